theremin_reg_bank: RTL

Register bank directly downstream of the AXI4-Lite register slave in theremin_io. It decodes the slave's single-cycle write/read strobes into control, interrupt and status registers, and buffers measurement samples in a small FIFO that software drains through a pop-on-read data register. It drives the control word and the interrupt line toward the rest of the theremin design.

---
 rtl/theremin_regs_pkg.sv | 37 +++
 rtl/theremin_reg_bank_if.sv | 29 ++
 rtl/theremin_sample_fifo.sv | 66 ++++++
 rtl/theremin_reg_bank.sv | 130 +++++++++++++
 4 files changed

// File: rtl/theremin_regs_pkg.sv
// Shared definitions for the theremin register bank: address map, bit indices, ID, CTRL layout.
// The SAMPLE_CNT register is built only when THEREMIN_REG_SAMPLE_CNT_EN is defined.
package theremin_regs_pkg;

  localparam int ADDR_CTRL       = 0;
  localparam int ADDR_STATUS     = 1;
  localparam int ADDR_IRQ_STATUS = 2;
  localparam int ADDR_FIFO_DATA  = 3;
  localparam int ADDR_THRESHOLD  = 4;
  localparam int ADDR_SAMPLE_CNT = 5;
  localparam int ADDR_ID         = 7;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_FLUSH  = 2;

  localparam int IRQ_THRESH   = 0;
  localparam int IRQ_OVERFLOW = 1;

  localparam logic [31:0] THEREMIN_REGS_ID = 32'h54524D31;

  typedef struct packed {
    logic [28:0] user;
    logic        flush;
    logic        irq_en;
    logic        enable;
  } ctrl_t;

  function automatic logic [31:0] status_word(
    input logic [8:0] level,
    input logic       empty,
    input logic       full
  );
    return {14'd0, full, empty, 7'd0, level};
  endfunction

endpackage

// File: rtl/theremin_reg_bank_if.sv
// Register strobe bus between the AXI4-Lite slave and the register bank,
// plus the sample push port.
interface theremin_reg_bank_if #(
  parameter int AW = 4,
  parameter int DW = 32
);
  logic          wren;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rden;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          sample_valid;
  logic [DW-1:0] sample_data;

  modport master (
    output wren, wr_addr, wr_data,
    output rden, rd_addr,
    output sample_valid, sample_data,
    input  rd_data
  );

  modport slave (
    input  wren, wr_addr, wr_data,
    input  rden, rd_addr,
    input  sample_valid, sample_data,
    output rd_data
  );
endinterface

// File: rtl/theremin_sample_fifo.sv
// Synchronous sample FIFO with flush; head word is presented combinationally.
// Power-of-two DEPTH lets the pointers wrap naturally.
module theremin_sample_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic [8:0]   level,
  output logic         empty,
  output logic         full
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_push, do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LW'(DEPTH));
  assign level   = 9'(level_q);
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      level_d = level_q + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is not reset; contents are meaningless after reset anyway.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/theremin_reg_bank.sv
// Register bank behind the AXI4-Lite slave: CTRL/IRQ/STATUS registers and sample FIFO.
// SAMPLE_CNT exists only when THEREMIN_REG_SAMPLE_CNT_EN is defined.
module theremin_reg_bank
  import theremin_regs_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int REG_ADDR_WIDTH     = 4,
  parameter int FIFO_DEPTH         = 16
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESETN,
  input  logic                          REG_WREN,
  input  logic [REG_ADDR_WIDTH-1:0]     REG_WR_ADDR,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] REG_WR_DATA,
  input  logic                          REG_RDEN,
  input  logic [REG_ADDR_WIDTH-1:0]     REG_RD_ADDR,
  output logic [C_S_AXI_DATA_WIDTH-1:0] REG_RD_DATA,
  input  logic                          SAMPLE_VALID,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] SAMPLE_DATA,
  output logic [C_S_AXI_DATA_WIDTH-1:0] CTRL_OUT,
  output logic                          IRQ
);
  ctrl_t       ctrl_q, ctrl_d;
  logic [8:0]  thresh_q, thresh_d;
  logic [1:0]  irq_st_q, irq_st_d;
  logic        irq_q, irq_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic [31:0] sample_cnt;

  logic [7:0]  wr_sel, rd_sel;
  logic        flush, pop_req, push_ok, ovf_set, thr_set;
  logic [31:0] head;
  logic [8:0]  level;
  logic        empty, full;

  assign wr_sel = ((REG_WR_ADDR >> 3) == '0 && REG_WREN) ?
                  (8'd1 << REG_WR_ADDR[2:0]) : 8'd0;
  assign rd_sel = ((REG_RD_ADDR >> 3) == '0 && REG_RDEN) ?
                  (8'd1 << REG_RD_ADDR[2:0]) : 8'd0;

  assign flush   = wr_sel[ADDR_CTRL] && REG_WR_DATA[CTRL_FLUSH];
  assign pop_req = rd_sel[ADDR_FIFO_DATA];
  // A push into a full FIFO still fits when the same cycle pops the head.
  assign push_ok = SAMPLE_VALID && ctrl_q.enable && !flush &&
                   (!full || (pop_req && !empty));
  assign ovf_set = SAMPLE_VALID && ctrl_q.enable && full &&
                   !(pop_req && !empty);
  assign thr_set = (thresh_q != '0) && (level >= thresh_q);

  theremin_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (32)
  ) u_fifo (
    .clk   (S_AXI_ACLK),
    .rst_n (S_AXI_ARESETN),
    .push  (push_ok),
    .pop   (pop_req),
    .flush (flush),
    .wdata (SAMPLE_DATA),
    .rdata (head),
    .level (level),
    .empty (empty),
    .full  (full)
  );

`ifdef THEREMIN_REG_SAMPLE_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  assign cnt_d      = cnt_q + 32'(push_ok);
  assign sample_cnt = cnt_q;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) cnt_q <= '0;
    else                cnt_q <= cnt_d;
  end
`else
  assign sample_cnt = '0;
`endif

  always_comb begin
    ctrl_d   = ctrl_q;
    thresh_d = thresh_q;
    if (wr_sel[ADDR_CTRL])      ctrl_d   = ctrl_t'(REG_WR_DATA);
    if (wr_sel[ADDR_THRESHOLD]) thresh_d = REG_WR_DATA[8:0];
    ctrl_d.flush = 1'b0;
    // Set beats a simultaneous write-one-to-clear.
    irq_st_d = irq_st_q;
    if (wr_sel[ADDR_IRQ_STATUS]) irq_st_d = irq_st_q & ~REG_WR_DATA[1:0];
    if (thr_set) irq_st_d[IRQ_THRESH]   = 1'b1;
    if (ovf_set) irq_st_d[IRQ_OVERFLOW] = 1'b1;
    irq_d = ctrl_q.irq_en && (irq_st_q != '0);
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (REG_RDEN) begin
      unique case (1'b1)
        rd_sel[ADDR_CTRL]:       rd_data_d = ctrl_q;
        rd_sel[ADDR_STATUS]:     rd_data_d = status_word(level, empty, full);
        rd_sel[ADDR_IRQ_STATUS]: rd_data_d = {30'd0, irq_st_q};
        rd_sel[ADDR_FIFO_DATA]:  rd_data_d = empty ? 32'd0 : head;
        rd_sel[ADDR_THRESHOLD]:  rd_data_d = {23'd0, thresh_q};
        rd_sel[ADDR_SAMPLE_CNT]: rd_data_d = sample_cnt;
        rd_sel[ADDR_ID]:         rd_data_d = THEREMIN_REGS_ID;
        default:                 rd_data_d = '0;
      endcase
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      ctrl_q    <= '0;
      thresh_q  <= '0;
      irq_st_q  <= '0;
      irq_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      thresh_q  <= thresh_d;
      irq_st_q  <= irq_st_d;
      irq_q     <= irq_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign REG_RD_DATA = rd_data_q;
  assign CTRL_OUT    = ctrl_q;
  assign IRQ         = irq_q;

endmodule
